// File: rtl/led_matrix_pkg.sv
// Shared defaults and scan-state encoding for the LED matrix scanner slice.
package led_matrix_pkg;

  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_COLS     = 8;
  localparam int unsigned DEF_PWM_BITS = 2;
  localparam int unsigned DEF_TICK_DIV = 1000;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] IDLE = 1'b0;
  localparam logic [STATE_W-1:0] SCAN = 1'b1;

endpackage

// File: rtl/led_matrix_scanner_tick_prescaler.sv
// Slot-tick prescaler: counts 0..TICK_DIV-1 while run is high, held at 0 otherwise.
module tick_prescaler
  import led_matrix_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = run && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scanner with double-buffered frames and per-row PWM brightness.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned PWM_BITS       = DEF_PWM_BITS,
  parameter int unsigned COL_ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [ROWS*COLS-1:0]     frame_in,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  input  logic [PWM_BITS-1:0]      brightness,
  output logic [ROWS-1:0]          row_out,
  output logic [COLS-1:0]          col_out,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_sync
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [COLS-1:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [PWM_BITS-1:0]  slot_q, slot_d;
  logic [RW-1:0]        row_q, row_d;
  logic [PWM_BITS-1:0]  bright_q, bright_d;
  logic [ROWS*COLS-1:0] active_q, active_d;
  logic [ROWS*COLS-1:0] shadow_q, shadow_d;
  logic                 shadow_full_q, shadow_full_d;
  logic                 swap_q, swap_d;
  logic [ROWS-1:0]      row_out_q, row_out_d;
  logic [COLS-1:0]      col_out_q, col_out_d;
  logic [RW-1:0]        row_idx_q, row_idx_d;
  logic                 frame_sync_q, frame_sync_d;

  logic            run;
  logic            tick;
  logic            slot_wrap;
  logic            boundary;
  logic            lit;
  logic [COLS-1:0] row_bits;

  // Leaving SCAN is seen by run in the same cycle, so outputs blank on the next edge.
  assign run       = (state_q == SCAN) && enable;
  assign slot_wrap = tick && (slot_q == '1);
  assign boundary  = slot_wrap && (row_q == ROW_LAST);
  assign row_bits  = active_q[int'(row_q)*COLS +: COLS];
  assign lit       = run && (slot_q <= bright_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d       = enable ? SCAN : IDLE;
    slot_d        = slot_q;
    row_d         = row_q;
    bright_d      = bright_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    swap_d        = 1'b0;

    if (!run) begin
      slot_d   = '0;
      row_d    = '0;
      bright_d = brightness;
    end else if (tick) begin
      slot_d = slot_q + 1'b1;
      if (slot_wrap) begin
        bright_d = brightness;
        row_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end
    end

    // Swap and write are mutually exclusive: a write needs shadow empty, a swap needs it full.
    if (boundary && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
      swap_d        = 1'b1;
    end
    if (frame_valid && !shadow_full_q) begin
      shadow_d      = frame_in;
      shadow_full_d = 1'b1;
    end
  end

  // Output stage lags the counters by one clk; frame_sync is delayed to line up with row 0.
  always_comb begin
    row_out_d    = '0;
    col_out_d    = COL_OFF;
    row_idx_d    = run ? row_q : '0;
    frame_sync_d = swap_q && run;
    if (lit) begin
      row_out_d = ROWS'(1) << row_q;
      col_out_d = (COL_ACTIVE_LOW != 0) ? ~row_bits : row_bits;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      row_q         <= '0;
      bright_q      <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      swap_q        <= 1'b0;
      row_out_q     <= '0;
      col_out_q     <= COL_OFF;
      row_idx_q     <= '0;
      frame_sync_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      row_q         <= row_d;
      bright_q      <= bright_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      swap_q        <= swap_d;
      row_out_q     <= row_out_d;
      col_out_q     <= col_out_d;
      row_idx_q     <= row_idx_d;
      frame_sync_q  <= frame_sync_d;
    end
  end

  assign row_out     = row_out_q;
  assign col_out     = col_out_q;
  assign row_idx     = row_idx_q;
  assign frame_sync  = frame_sync_q;
  assign frame_ready = ~shadow_full_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: a time-indexed scan model pushes expected outputs per clk.
module tb_led_matrix_scanner;

  localparam int unsigned ROWS     = 8;
  localparam int unsigned COLS     = 8;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned PWM_BITS = 2;

  localparam logic [63:0] DIAG  = 64'h8040_2010_0804_0201;
  localparam logic [63:0] PAT_A = 64'hF0F0_0F0F_AA55_33CC;
  localparam logic [63:0] PAT_B = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT_C = 64'hFFFF_0000_FFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [1:0]  brightness;
  logic [7:0]  row_out;
  logic [7:0]  col_out;
  logic [2:0]  row_idx;
  logic        frame_sync;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [2:0] idx;
    logic       fs;
    logic       rdy;
  } obs_t;

  obs_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model: m_k is the index of the scan clk currently shown (-1 = blank entry clk).
  bit          m_scan;
  int          m_k;
  logic [1:0]  m_rowb;
  logic [63:0] m_active;
  logic [63:0] m_shadow;
  bit          m_full;
  bit          m_fsp;

  always #5 clk = ~clk;

  led_matrix_scanner #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .TICK_DIV       (TICK_DIV),
    .PWM_BITS       (PWM_BITS),
    .COL_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .brightness  (brightness),
    .row_out     (row_out),
    .col_out     (col_out),
    .row_idx     (row_idx),
    .frame_sync  (frame_sync)
  );

  function automatic obs_t blank(input logic rdy);
    obs_t o;
    o.row = 8'h00;
    o.col = 8'hFF;
    o.idx = 3'd0;
    o.fs  = 1'b0;
    o.rdy = rdy;
    return o;
  endfunction

  function automatic obs_t actual();
    return {row_out, col_out, row_idx, frame_sync, frame_ready};
  endfunction

  task automatic model_reset();
    m_scan   = 1'b0;
    m_k      = -1;
    m_rowb   = '0;
    m_active = '0;
    m_shadow = '0;
    m_full   = 1'b0;
    m_fsp    = 1'b0;
  endtask

  // Called right after each negedge, before inputs change: models the posedge just passed.
  task automatic model_edge();
    obs_t e;
    bit   rdy_pre;
    int   r;
    int   s;
    rdy_pre = !m_full;
    if (enable) begin
      m_k    = m_scan ? m_k + 1 : -1;
      m_scan = 1'b1;
    end else begin
      m_scan = 1'b0;
      m_k    = -1;
    end
    e = blank(1'b0);
    if (m_k >= 0) begin
      r     = (m_k / 16) % 8;
      s     = (m_k % 16) / 4;
      e.idx = 3'(r);
      if (s <= int'(m_rowb)) begin
        e.row = 8'(1 << r);
        e.col = ~m_active[r*8 +: 8];
      end
      e.fs = m_fsp;
    end
    m_fsp = 1'b0;
    if (m_scan && (m_k < 0 || (m_k % 16) == 15)) m_rowb = brightness;
    if (m_k >= 0 && (m_k % 128) == 127 && m_full) begin
      m_active = m_shadow;
      m_full   = 1'b0;
      m_fsp    = 1'b1;
    end
    if (frame_valid && rdy_pre) begin
      m_shadow = frame_in;
      m_full   = 1'b1;
    end
    e.rdy = !m_full;
    expq.push_back(e);
  endtask

  task automatic test_reset();
    obs_t e, a;
    rst = 1'b0; enable = 1'b0; frame_valid = 1'b0; frame_in = '0; brightness = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expq.push_back(blank(1'b1));
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL reset i=%0d got=%h want=%h", i, a, e);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_scan_no_frame();
    obs_t e, a;
    enable = 1'b1; brightness = 2'd3;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scan_no_frame i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
    end
  endtask

  task automatic test_frame_swap();
    obs_t e, a;
    int   fs_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (frame_sync) fs_seen++;
      if (a !== e) begin
        n_err++;
        $display("FAIL frame_swap i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
      frame_valid = (i == 2);
      frame_in    = (i == 2) ? DIAG : '0;
    end
    n_cmp++;
    if (fs_seen !== 1) begin
      n_err++;
      $display("FAIL frame_swap_pulses got=%0d want=1", fs_seen);
    end
  endtask

  task automatic test_brightness();
    obs_t e, a;
    brightness = 2'd0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL brightness i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
      if (i == 40) brightness = 2'd1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    int   fs_seen = 0;
    brightness = 2'd3;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (frame_sync) fs_seen++;
      if (a !== e) begin
        n_err++;
        $display("FAIL back_to_back i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
      frame_valid = (i < 6);
      frame_in    = (i == 0) ? PAT_A : PAT_B;
    end
    frame_valid = 1'b0;
    n_cmp++;
    if (fs_seen !== 1) begin
      n_err++;
      $display("FAIL back_to_back_pulses got=%0d want=1", fs_seen);
    end
  endtask

  task automatic test_disable();
    obs_t e, a;
    bit   dropped = 1'b0;
    int   drop_i  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL disable i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
      if (!dropped && m_k >= 0 && ((m_k / 16) % 8) == 5 && (m_k % 16) == 4) begin
        enable  = 1'b0;
        dropped = 1'b1;
        drop_i  = i;
      end else if (dropped && i == drop_i + 3) begin
        enable = 1'b1;
      end
    end
    enable = 1'b1;
    n_cmp++;
    if (!dropped) begin
      n_err++;
      $display("FAIL disable_timeout row 5 not reached got=0 want=1");
    end
  endtask

  task automatic test_async_reset();
    obs_t e, a;
    bit   wrote = 1'b0;
    bit   hit   = 1'b0;
    int   fs_seen = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL pre_reset i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
      frame_valid = 1'b0;
      if (!wrote && m_k >= 0 && ((m_k / 16) % 8) == 2) begin
        frame_valid = 1'b1;
        frame_in    = PAT_C;
        wrote       = 1'b1;
      end else if (m_k >= 0 && ((m_k / 16) % 8) == 3 && (m_k % 16) == 6) begin
        hit = 1'b1;
        #2 rst = 1'b0;
        #1;
        expq.push_back(blank(1'b1));
        e = expq.pop_front(); a = actual(); n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL async_reset got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                   a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
        end
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL async_reset_timeout row 3 not reached got=0 want=1");
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1; enable = 1'b1; brightness = 2'd3; frame_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      model_edge();
      e = expq.pop_front(); a = actual(); n_cmp++;
      if (frame_sync) fs_seen++;
      if (a !== e) begin
        n_err++;
        $display("FAIL post_reset i=%0d got row=%h col=%h idx=%0d fs=%b rdy=%b want row=%h col=%h idx=%0d fs=%b rdy=%b",
                 i, a.row, a.col, a.idx, a.fs, a.rdy, e.row, e.col, e.idx, e.fs, e.rdy);
      end
    end
    n_cmp++;
    if (fs_seen !== 0) begin
      n_err++;
      $display("FAIL post_reset_pulses got=%0d want=0", fs_seen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_no_frame();
    test_frame_swap();
    test_brightness();
    test_back_to_back();
    test_disable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
